// File: rtl/uart_rx_fifo_leds.sv
// UART receiver: 16x oversampling, majority vote, optional parity,
// FWFT FIFO, sticky error flags and active-low LED mirror.
module uart_rx_fifo_leds #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic                   rd_en,
    input  logic                   clr_err,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   overrun,
    output logic                   rst_led,
    output logic                   WR2c_led,
    output logic [7:0]             leds
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = $clog2(DIV + 1);
    localparam int AW      = $clog2(DEPTH);
    localparam int BW      = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic                 sync1;
    logic                 rxs;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    logic [3:0]           cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 s7;
    logic                 s8;
    logic                 vote;
    logic                 par_bad;
    logic                 armed;
    logic                 resolve;
    logic                 accept;
    logic                 set_fe;
    logic                 set_pe;
    logic                 set_ov;
    logic [7:0]           ext;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wp;
    logic [AW-1:0]        rp;
    logic                 full;
    logic                 pop;
    logic                 push;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    assign vote    = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
    assign resolve = (state == STOP) && tick && (cnt == 4'd9);
    assign accept  = resolve && vote && !par_bad;
    assign set_fe  = resolve && !vote;
    assign set_pe  = resolve && vote && par_bad;

    // armed drops after a framing error so a held break cannot retrigger
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            s7      <= 1'b1;
            s8      <= 1'b1;
            par_bad <= 1'b0;
            armed   <= 1'b1;
        end else if (tick) begin
            if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == 4'd7) begin
                s7 <= rxs;
            end
            if (cnt == 4'd8) begin
                s8 <= rxs;
            end
            unique case (state)
                IDLE: begin
                    if (!armed) begin
                        armed <= rxs;
                    end else if (!rxs) begin
                        state   <= START;
                        cnt     <= '0;
                        par_bad <= 1'b0;
                    end
                end
                START: begin
                    if (cnt == 4'd9 && vote) begin
                        state <= IDLE;
                    end else if (cnt == 4'd15) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (cnt == 4'd9) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                    end
                    if (cnt == 4'd15) begin
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (cnt == 4'd9) begin
                        par_bad <= ((^shreg) ^ vote) != (PARITY == 1);
                    end
                    if (cnt == 4'd15) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt == 4'd9) begin
                        state <= IDLE;
                        armed <= vote;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_valid = (fifo_count != '0);
    assign full     = (fifo_count == (AW + 1)'(DEPTH));
    assign pop      = rd_en && rd_valid;
    assign push     = accept && (!full || pop);
    assign set_ov   = accept && full && !pop;
    assign rd_data  = mem[rp];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    always_comb begin
        ext                  = '0;
        ext[DATA_BITS-1:0]   = shreg;
    end

    // a new error event wins over a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            rst_led    <= 1'b0;
            WR2c_led   <= 1'b1;
            leds       <= 8'hFF;
        end else begin
            frame_err  <= set_fe | (frame_err & ~clr_err);
            parity_err <= set_pe | (parity_err & ~clr_err);
            overrun    <= set_ov | (overrun & ~clr_err);
            if (accept) begin
                leds     <= ~ext;
                rst_led  <= 1'b1;
                WR2c_led <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_leds.sv
// Randomized bench for uart_rx_fifo_leds: three configurations
// checked against a queue-level model of received characters.
module tb_uart_rx_fifo_leds;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] rx;
    logic [2:0] rd_en;
    logic [2:0] clr;

    logic [7:0] a_data, b_data, a_leds, b_leds, c_leds;
    logic [6:0] c_data;
    logic [2:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;
    logic a_valid, a_fe, a_pe, a_ov, a_rl, a_wl;
    logic b_valid, b_fe, b_pe, b_ov, b_rl, b_wl;
    logic c_valid, c_fe, c_pe, c_ov, c_rl, c_wl;

    uart_rx_fifo_leds #(.CLK_FREQ(16_000_000), .BAUD(1_000_000),
        .DATA_BITS(8), .PARITY(0), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst[0]), .rx(rx[0]), .rd_en(rd_en[0]),
        .clr_err(clr[0]), .rd_data(a_data), .rd_valid(a_valid),
        .fifo_count(a_cnt), .frame_err(a_fe), .parity_err(a_pe),
        .overrun(a_ov), .rst_led(a_rl), .WR2c_led(a_wl), .leds(a_leds));

    uart_rx_fifo_leds #(.CLK_FREQ(16_000_000), .BAUD(1_000_000),
        .DATA_BITS(8), .PARITY(2), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst[1]), .rx(rx[1]), .rd_en(rd_en[1]),
        .clr_err(clr[1]), .rd_data(b_data), .rd_valid(b_valid),
        .fifo_count(b_cnt), .frame_err(b_fe), .parity_err(b_pe),
        .overrun(b_ov), .rst_led(b_rl), .WR2c_led(b_wl), .leds(b_leds));

    uart_rx_fifo_leds #(.CLK_FREQ(16_000_000), .BAUD(1_000_000),
        .DATA_BITS(7), .PARITY(1), .DEPTH(2)) dut_c (
        .clk(clk), .rst(rst[2]), .rx(rx[2]), .rd_en(rd_en[2]),
        .clr_err(clr[2]), .rd_data(c_data), .rd_valid(c_valid),
        .fifo_count(c_cnt), .frame_err(c_fe), .parity_err(c_pe),
        .overrun(c_ov), .rst_led(c_rl), .WR2c_led(c_wl), .leds(c_leds));

    int checks = 0;
    int errors = 0;

    int depth_of [3] = '{4, 4, 2};
    int nbits_of [3] = '{8, 8, 7};
    int pmode    [3] = '{0, 2, 1};

    logic [7:0] mq [3][16];
    int         mcnt [3];
    bit         m_fe [3];
    bit         m_pe [3];
    bit         m_ov [3];
    bit         m_seen [3];
    logic [7:0] m_led [3];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int i);
        mcnt[i]   = 0;
        m_fe[i]   = 0;
        m_pe[i]   = 0;
        m_ov[i]   = 0;
        m_seen[i] = 0;
        m_led[i]  = 8'hFF;
    endtask

    task automatic mpop(input int i);
        if (mcnt[i] > 0) begin
            for (int k = 1; k < mcnt[i]; k++) mq[i][k-1] = mq[i][k];
            mcnt[i]--;
        end
    endtask

    task automatic model_frame(input int i, input logic [7:0] dm,
                               input int par, input bit ok,
                               input bit pop_same);
        if (!ok) begin
            m_fe[i] = 1;
        end else if (pmode[i] != 0 &&
                     (((^dm) ^ par[0]) != (pmode[i] == 1))) begin
            m_pe[i] = 1;
        end else begin
            if (pop_same) mpop(i);
            if (mcnt[i] < depth_of[i]) begin
                mq[i][mcnt[i]] = dm;
                mcnt[i]++;
            end else begin
                m_ov[i] = 1;
            end
            m_led[i]  = ~dm;
            m_seen[i] = 1;
        end
    endtask

    function automatic int good_par(input int i, input logic [7:0] d);
        logic [7:0] dm;
        dm = d & 8'((1 << nbits_of[i]) - 1);
        return (pmode[i] == 1) ? int'(~(^dm)) : int'(^dm);
    endfunction

    task automatic drv(input int i, input logic v, input int n);
        rx[i] = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int i, input logic [7:0] d, input int par,
                         input int stop_low, input bit pop_same);
        logic [7:0] dm;
        dm = d & 8'((1 << nbits_of[i]) - 1);
        drv(i, 1'b0, 16);
        for (int b = 0; b < nbits_of[i]; b++) drv(i, dm[b], 16);
        if (pmode[i] != 0) drv(i, par[0], 16);
        if (stop_low > 0) begin
            drv(i, 1'b0, 16 * stop_low);
            drv(i, 1'b1, 32);
        end else if (pop_same) begin
            drv(i, 1'b1, 12);
            rd_en[i] = 1'b1;
            drv(i, 1'b1, 1);
            rd_en[i] = 1'b0;
            drv(i, 1'b1, 3);
        end else begin
            drv(i, 1'b1, 16);
        end
        model_frame(i, dm, par, stop_low == 0, pop_same);
    endtask

    task automatic pop(input int i);
        rd_en[i] = 1'b1;
        @(negedge clk);
        rd_en[i] = 1'b0;
        mpop(i);
    endtask

    task automatic clear(input int i);
        clr[i] = 1'b1;
        @(negedge clk);
        clr[i] = 1'b0;
        m_fe[i] = 0;
        m_pe[i] = 0;
        m_ov[i] = 0;
    endtask

    task automatic chk_state(input int i, input string tag);
        logic [7:0]  d, l;
        logic [31:0] c;
        logic        v, f, p, o, r, w;
        d = '0; l = '0; c = '0;
        v = 0; f = 0; p = 0; o = 0; r = 0; w = 0;
        case (i)
            0: begin
                d = a_data; l = a_leds; c = 32'(a_cnt); v = a_valid;
                f = a_fe; p = a_pe; o = a_ov; r = a_rl; w = a_wl;
            end
            1: begin
                d = b_data; l = b_leds; c = 32'(b_cnt); v = b_valid;
                f = b_fe; p = b_pe; o = b_ov; r = b_rl; w = b_wl;
            end
            default: begin
                d = {1'b0, c_data}; l = c_leds; c = 32'(c_cnt);
                v = c_valid; f = c_fe; p = c_pe; o = c_ov;
                r = c_rl; w = c_wl;
            end
        endcase
        check($sformatf("%s.cnt", tag), c, mcnt[i]);
        check($sformatf("%s.valid", tag), 32'(v), 32'(mcnt[i] > 0));
        if (mcnt[i] > 0) check($sformatf("%s.data", tag), d, mq[i][0]);
        check($sformatf("%s.leds", tag), l, m_led[i]);
        check($sformatf("%s.fe", tag), 32'(f), 32'(m_fe[i]));
        check($sformatf("%s.pe", tag), 32'(p), 32'(m_pe[i]));
        check($sformatf("%s.ov", tag), 32'(o), 32'(m_ov[i]));
        check($sformatf("%s.rst_led", tag), 32'(r), 32'(m_seen[i]));
        check($sformatf("%s.wr2c", tag), 32'(w), 32'(!m_seen[i]));
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] v;
        int         p;
        rst   = '1;
        rx    = '1;
        rd_en = '0;
        clr   = '0;
        for (int i = 0; i < 3; i++) model_reset(i);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_state(i, $sformatf("reset%0d", i));
        rst = '0;
        repeat (4) @(negedge clk);

        frame(0, 8'h41, -1, 0, 0);
        chk_state(0, "a41");
        pop(0);
        chk_state(0, "a41pop");

        rx[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx[0] = 1'b1;
        repeat (40) @(negedge clk);
        chk_state(0, "glitch");

        frame(0, 8'h55, -1, 2, 0);
        frame(0, 8'h33, -1, 0, 0);
        chk_state(0, "break");
        clear(0);
        chk_state(0, "clr_fe");
        pop(0);

        for (int k = 1; k <= 5; k++) frame(0, 8'(k), -1, 0, 0);
        chk_state(0, "ovr");
        for (int k = 0; k < 4; k++) begin
            pop(0);
            chk_state(0, $sformatf("drain%0d", k));
        end
        pop(0);
        chk_state(0, "empty_pop");
        clear(0);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 1) pop(0);
            d = 8'($urandom);
            frame(0, d, -1, 0, 0);
            chk_state(0, $sformatf("rand_a%0d", k));
        end

        v = 8'hA5;
        drv(0, 1'b0, 16);
        for (int b = 0; b < 4; b++) drv(0, v[b], 16);
        drv(0, v[4], 8);
        rst[0] = 1'b1;
        rx[0]  = 1'b1;
        repeat (2) @(negedge clk);
        model_reset(0);
        chk_state(0, "midrst");
        rst[0] = 1'b0;
        drv(0, 1'b1, 40);
        frame(0, 8'h5A, -1, 0, 0);
        chk_state(0, "after_rst");

        frame(1, 8'h07, 0, 0, 0);
        chk_state(1, "b07p0");
        frame(1, 8'h07, 1, 0, 0);
        chk_state(1, "b07p1");
        clear(1);
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 2) == 0) pop(1);
            d = 8'($urandom);
            p = good_par(1, d);
            if ($urandom_range(0, 3) == 0) p = 1 - p;
            frame(1, d, p, 0, 0);
            chk_state(1, $sformatf("rand_b%0d", k));
        end

        frame(2, 8'h11, good_par(2, 8'h11), 0, 0);
        frame(2, 8'h22, good_par(2, 8'h22), 0, 0);
        chk_state(2, "c_full");
        frame(2, 8'h7F, good_par(2, 8'h7F), 0, 1);
        chk_state(2, "c_pushpop");
        pop(2);
        chk_state(2, "c_pop1");
        pop(2);
        chk_state(2, "c_pop2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
